// File: rtl/preg_reclaim_if.sv
// Commit-to-free-list reclaim bus: dual-slot commit side plus
// the one-per-cycle release strobe and status/error flags.
// Optional PREG_DOUBLE_FREE_CHECK_EN adds double_free_err.
interface preg_reclaim_if #(
  parameter int DEPTH = 16
);
  localparam int OW = $clog2(DEPTH) + 1;

  logic [1:0]    commit_valid;
  logic [5:0]    commit_old_phys0;
  logic [5:0]    commit_old_phys1;
  logic          commit_ready;
  logic          free_en;
  logic [5:0]    free_phys;
  logic [OW-1:0] occupancy;
  logic          overflow_err;
  logic          range_err;
`ifdef PREG_DOUBLE_FREE_CHECK_EN
  logic          double_free_err;

  modport master (
    output commit_valid, commit_old_phys0, commit_old_phys1,
    input  commit_ready, free_en, free_phys, occupancy,
    input  overflow_err, range_err, double_free_err
  );
  modport slave (
    input  commit_valid, commit_old_phys0, commit_old_phys1,
    output commit_ready, free_en, free_phys, occupancy,
    output overflow_err, range_err, double_free_err
  );
`else
  modport master (
    output commit_valid, commit_old_phys0, commit_old_phys1,
    input  commit_ready, free_en, free_phys, occupancy,
    input  overflow_err, range_err
  );
  modport slave (
    input  commit_valid, commit_old_phys0, commit_old_phys1,
    output commit_ready, free_en, free_phys, occupancy,
    output overflow_err, range_err
  );
`endif
endinterface

// File: rtl/preg_reclaim_queue.sv
// Reclaim FIFO: takes up to two retiring old tags per cycle from
// commit, releases one per cycle (registered) to the free list.
// Ports: clk, reset (async, active-high), bus (preg_reclaim_if.slave):
//   commit_valid/commit_old_phys0/1 in, commit_ready, free_en,
//   free_phys, occupancy, overflow_err, range_err out.
// Optional macro PREG_DOUBLE_FREE_CHECK_EN: pending-tag mask that
// drops duplicate releases and pulses bus.double_free_err.
module preg_reclaim_queue #(
  parameter int PHYS_REGS = 64,
  parameter int DEPTH     = 16
) (
  input  logic           clk,
  input  logic           reset,
  preg_reclaim_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int TW = 6;
  localparam logic [TW:0]   PR_LIM  = (TW+1)'(PHYS_REGS);
  localparam logic [OW-1:0] RDY_LIM = OW'(DEPTH - 2);

  logic [TW-1:0] mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          fen_q, fen_d;
  logic [TW-1:0] fph_q, fph_d;
  logic          ovf_q, ovf_d;
  logic          rng_q, rng_d;

  logic          ready;
  logic          v0, v1;
  logic [TW-1:0] t0, t1;
  logic          in0, in1;
  logic          dup0, dup1;
  logic          acc0, acc1;
  logic          deq;
  logic [OW-1:0] enq_n;
  logic [AW-1:0] wa1;

  assign v0 = bus.commit_valid[0];
  assign v1 = bus.commit_valid[1];
  assign t0 = bus.commit_old_phys0;
  assign t1 = bus.commit_old_phys1;

  // Ready looks only at the registered count; a same-cycle
  // dequeue is deliberately not credited.
  assign ready = (occ_q <= RDY_LIM);
  assign in0   = ({1'b0, t0} < PR_LIM);
  assign in1   = ({1'b0, t1} < PR_LIM);

`ifdef PREG_DOUBLE_FREE_CHECK_EN
  logic [PHYS_REGS-1:0] pend_q, pend_d;
  logic                 dfe_q, dfe_d;

  // Slot 1 repeating slot 0's tag loses even when slot 0 is new.
  assign dup0 = in0 && pend_q[t0];
  assign dup1 = in1 && (pend_q[t1] || (v0 && in0 && t1 == t0));
  assign bus.double_free_err = dfe_q;
`else
  assign dup0 = 1'b0;
  assign dup1 = 1'b0;
`endif

  assign acc0  = ready && v0 && in0 && !dup0;
  assign acc1  = ready && v1 && in1 && !dup1;
  assign enq_n = OW'(acc0) + OW'(acc1);
  assign deq   = (occ_q != '0);
  assign wa1   = acc0 ? tail_q + AW'(1) : tail_q;

  always_comb begin
    head_d = head_q + AW'(deq);
    tail_d = tail_q + AW'(enq_n);
    occ_d  = occ_q + enq_n - OW'(deq);
    fen_d  = deq;
    fph_d  = deq ? mem_q[head_q] : fph_q;
    ovf_d  = !ready && (v0 || v1);
    rng_d  = ready && ((v0 && !in0) || (v1 && !in1));
  end

`ifdef PREG_DOUBLE_FREE_CHECK_EN
  always_comb begin
    pend_d = pend_q;
    dfe_d  = ready && ((v0 && dup0) || (v1 && dup1));
    if (deq)
      pend_d[mem_q[head_q]] = 1'b0;
    if (acc0)
      pend_d[t0] = 1'b1;
    if (acc1)
      pend_d[t1] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      dfe_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      dfe_q  <= dfe_d;
    end
  end
`endif

  // Storage needs no reset: occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (acc0)
      mem_q[tail_q] <= t0;
    if (acc1)
      mem_q[wa1] <= t1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      fen_q  <= 1'b0;
      fph_q  <= '0;
      ovf_q  <= 1'b0;
      rng_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      fen_q  <= fen_d;
      fph_q  <= fph_d;
      ovf_q  <= ovf_d;
      rng_q  <= rng_d;
    end
  end

  assign bus.commit_ready = ready;
  assign bus.free_en      = fen_q;
  assign bus.free_phys    = fph_q;
  assign bus.occupancy    = occ_q;
  assign bus.overflow_err = ovf_q;
  assign bus.range_err    = rng_q;
endmodule

// File: tb/tb_preg_reclaim_queue.sv
// Scoreboard bench for preg_reclaim_queue: directed commit
// traffic, monitor compares every free strobe against the queue.
module tb_preg_reclaim_queue;
  localparam int DEPTH = 16;
  localparam int PR    = 48;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  preg_reclaim_if #(.DEPTH(DEPTH)) bus ();

  preg_reclaim_queue #(
    .PHYS_REGS(PR),
    .DEPTH    (DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  int peak     = 0;
  logic [5:0] exp_q [$];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    logic [5:0] e;
    if (!reset) begin
      if (int'(bus.occupancy) > peak)
        peak = int'(bus.occupancy);
      if (bus.free_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_free actual=%0d required=none",
                   bus.free_phys);
        end else begin
          e = exp_q.pop_front();
          chk("free_order", int'(bus.free_phys), int'(e));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [5:0] a,
                       input logic [5:0] b);
    bus.commit_valid     = v;
    bus.commit_old_phys0 = a;
    bus.commit_old_phys1 = b;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++)
      step();
    step();
    step();
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_occ", int'(bus.occupancy), 0);
  endtask

  initial begin
    reset = 1'b1;
    drive(2'b00, 6'd0, 6'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // idle after reset
    repeat (5) step();
    @(negedge clk);
    chk("rst_fen", int'(bus.free_en), 0);
    chk("rst_fphys", int'(bus.free_phys), 0);
    chk("rst_occ", int'(bus.occupancy), 0);
    chk("rst_ready", int'(bus.commit_ready), 1);
    chk("rst_ovf", int'(bus.overflow_err), 0);
    chk("rst_rng", int'(bus.range_err), 0);
`ifdef PREG_DOUBLE_FREE_CHECK_EN
    chk("rst_dfe", int'(bus.double_free_err), 0);
`endif

    // single release, latency
    drive(2'b01, 6'd37, 6'd0);
    exp_q.push_back(6'd37);
    step();
    drive(2'b00, 6'd0, 6'd0);
    @(negedge clk);
    chk("lat_occ1", int'(bus.occupancy), 1);
    chk("lat_fen0", int'(bus.free_en), 0);
    step();
    @(negedge clk);
    chk("lat_fen1", int'(bus.free_en), 1);
    chk("lat_occ0", int'(bus.occupancy), 0);
    drain();

    // dual release x4
    peak = 0;
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 6'd10, 6'd11);
      exp_q.push_back(6'd10);
      exp_q.push_back(6'd11);
      step();
    end
    drive(2'b00, 6'd0, 6'd0);
    drain();
    chk("dual_peak", peak, 5);

    // fill until not ready, then one held cycle
    for (int k = 0; k < 14; k++) begin
      drive(2'b11, 6'(2*k), 6'(2*k+1));
      exp_q.push_back(6'(2*k));
      exp_q.push_back(6'(2*k+1));
      step();
    end
    @(negedge clk);
    chk("full_occ", int'(bus.occupancy), 15);
    chk("full_ready", int'(bus.commit_ready), 0);
    chk("full_ovf_pre", int'(bus.overflow_err), 0);
    drive(2'b11, 6'd40, 6'd41);
    step();
    drive(2'b00, 6'd0, 6'd0);
    @(negedge clk);
    chk("ovf_pulse", int'(bus.overflow_err), 1);
    chk("ovf_occ", int'(bus.occupancy), 14);
    chk("ovf_ready", int'(bus.commit_ready), 1);
    step();
    @(negedge clk);
    chk("ovf_clear", int'(bus.overflow_err), 0);
    drain();

    // out-of-range slot 0
    drive(2'b11, 6'd50, 6'd5);
    exp_q.push_back(6'd5);
    step();
    drive(2'b00, 6'd0, 6'd0);
    @(negedge clk);
    chk("rng_pulse", int'(bus.range_err), 1);
    chk("rng_occ", int'(bus.occupancy), 1);
    chk("rng_ovf", int'(bus.overflow_err), 0);
    step();
    @(negedge clk);
    chk("rng_clear", int'(bus.range_err), 0);
    drain();

    // slot 1 only
    drive(2'b10, 6'd0, 6'd20);
    exp_q.push_back(6'd20);
    step();
    drive(2'b00, 6'd0, 6'd0);
    @(negedge clk);
    chk("s1_occ", int'(bus.occupancy), 1);
    drain();

    // duplicate release of 9
    drive(2'b01, 6'd9, 6'd0);
    exp_q.push_back(6'd9);
    step();
    drive(2'b01, 6'd9, 6'd0);
`ifndef PREG_DOUBLE_FREE_CHECK_EN
    exp_q.push_back(6'd9);
`endif
    step();
    drive(2'b00, 6'd0, 6'd0);
    @(negedge clk);
`ifdef PREG_DOUBLE_FREE_CHECK_EN
    chk("dup_err", int'(bus.double_free_err), 1);
    chk("dup_occ", int'(bus.occupancy), 0);
`else
    chk("dup_occ", int'(bus.occupancy), 1);
`endif
    drain();
    drive(2'b01, 6'd9, 6'd0);
    exp_q.push_back(6'd9);
    step();
    drive(2'b00, 6'd0, 6'd0);
    @(negedge clk);
    chk("re9_occ", int'(bus.occupancy), 1);
`ifdef PREG_DOUBLE_FREE_CHECK_EN
    chk("re9_err", int'(bus.double_free_err), 0);
`endif
    drain();

    // reset mid-operation drops buffered tags
    drive(2'b11, 6'd30, 6'd31);
    step();
    drive(2'b00, 6'd0, 6'd0);
    reset = 1'b1;
    #1;
    chk("mrst_occ", int'(bus.occupancy), 0);
    chk("mrst_fen", int'(bus.free_en), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("mrst_idle_occ", int'(bus.occupancy), 0);
    chk("mrst_ready", int'(bus.commit_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
